// File: rtl/gps_counter_spi_master.sv
// gps_counter_spi_master
//   SPI master for the serial port of the GPS clock counter. A read fetches the
//   1PPS-latched count and its valid flag; a write loads the PPS compare value.
//   Every transaction, and the state after reset, ends with one spi_clk pulse
//   while spi_sen is high so the slave clears its started/update state.
//
// Optional build macro: GPS_AUTO_POLL_EN adds one_pps_i. A rising edge on it
//   queues a single read, which is launched the next time the block is idle.
//
// Ports
//   clk_i        system clock
//   nreset_i     asynchronous active-low reset
//   one_pps_i    1PPS strobe, synchronous to clk_i (GPS_AUTO_POLL_EN only)
//   start_i      single-cycle request, sampled only while busy_o is low
//   wr_i         1 = write compare value, 0 = read count
//   wr_data_i    compare value, captured when start_i is accepted
//   busy_o       transaction or flush in progress
//   done_o       one-cycle pulse at the end of a transaction
//   rd_data_o    count from the last read
//   rd_flag_o    valid/new-data flag from the last read
//   spi_clk_o    serial clock, idles low
//   spi_sen_o    serial enable, active low, idles high
//   spi_mosi_o   to the slave's spi_in
//   spi_miso_i   from the slave's spi_out

module gps_counter_spi_master #(
    parameter int unsigned CLK_DIV          = 4,
    parameter int unsigned COUNTER_BITS     = 16,
    parameter int unsigned COMPARE_PPS_BITS = 28
) (
    input  logic                        clk_i,
    input  logic                        nreset_i,
`ifdef GPS_AUTO_POLL_EN
    input  logic                        one_pps_i,
`endif
    input  logic                        start_i,
    input  logic                        wr_i,
    input  logic [COMPARE_PPS_BITS-1:0] wr_data_i,
    output logic                        busy_o,
    output logic                        done_o,
    output logic [COUNTER_BITS-1:0]     rd_data_o,
    output logic                        rd_flag_o,
    output logic                        spi_clk_o,
    output logic                        spi_sen_o,
    output logic                        spi_mosi_o,
    input  logic                        spi_miso_i
);

    localparam int unsigned RdBits  = COUNTER_BITS + 1;
    localparam int unsigned WrBits  = COMPARE_PPS_BITS + 1;
    localparam int unsigned MaxBits = (WrBits > RdBits) ? WrBits : RdBits;
    localparam int unsigned BitCntW = $clog2(MaxBits + 1);
    localparam int unsigned DivW    = $clog2(CLK_DIV);

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StHigh,
        StLow,
        StFlushLow,
        StFlushHigh,
        StDone
    } state_e;

    state_e                      state_q, state_d;
    logic [DivW-1:0]             div_q, div_d;
    logic [BitCntW-1:0]          bit_cnt_q, bit_cnt_d;
    logic                        wr_q, wr_d;
    logic [COMPARE_PPS_BITS-1:0] wr_shift_q, wr_shift_d;
    logic [COUNTER_BITS:0]       cap_q, cap_d;
    logic                        mosi_q, mosi_d;
    logic [COUNTER_BITS-1:0]     rd_data_q, rd_data_d;
    logic                        rd_flag_q, rd_flag_d;
    // Set by reset: the first flush returns to idle without a done pulse.
    logic                        boot_q, boot_d;

    logic div_last;
    logic go;
    logic go_wr;

`ifdef GPS_AUTO_POLL_EN
    logic pps_q;
    logic pend_q, pend_d;
    logic pend_now;
`endif

    assign div_last = (div_q == DivW'(CLK_DIV - 1));

    always_comb begin
        state_d    = state_q;
        div_d      = div_last ? '0 : div_q + DivW'(1);
        bit_cnt_d  = bit_cnt_q;
        wr_d       = wr_q;
        wr_shift_d = wr_shift_q;
        cap_d      = cap_q;
        mosi_d     = mosi_q;
        rd_data_d  = rd_data_q;
        rd_flag_d  = rd_flag_q;
        boot_d     = boot_q;
        go         = 1'b0;
        go_wr      = 1'b0;
`ifdef GPS_AUTO_POLL_EN
        pend_now   = pend_q | (one_pps_i & ~pps_q);
        pend_d     = pend_now;
`endif

        unique case (state_q)
            StIdle: begin
                div_d = '0;
                if (start_i) begin
                    go    = 1'b1;
                    go_wr = wr_i;
`ifdef GPS_AUTO_POLL_EN
                end else if (pend_now) begin
                    go     = 1'b1;
                    go_wr  = 1'b0;
                    pend_d = 1'b0;
`endif
                end
            end
            StSetup, StLow: begin
                if (div_last) begin
                    state_d = StHigh;
                    // miso is sampled on the last cycle of every low phase
                    if (!wr_q) begin
                        cap_d = {cap_q[COUNTER_BITS-1:0], spi_miso_i};
                    end
                end
            end
            StHigh: begin
                if (div_last) begin
                    bit_cnt_d = bit_cnt_q - BitCntW'(1);
                    if (bit_cnt_q == BitCntW'(1)) begin
                        state_d = StFlushLow;
                        mosi_d  = 1'b0;
                    end else begin
                        state_d = StLow;
                        // Next compare bit appears in the first cycle of low;
                        // a read keeps mosi at 1.
                        if (wr_q) begin
                            mosi_d     = wr_shift_q[COMPARE_PPS_BITS-1];
                            wr_shift_d = wr_shift_q << 1;
                        end
                    end
                end
            end
            StFlushLow: begin
                if (div_last) begin
                    state_d = StFlushHigh;
                end
            end
            StFlushHigh: begin
                if (div_last) begin
                    if (boot_q) begin
                        state_d = StIdle;
                        boot_d  = 1'b0;
                    end else begin
                        state_d = StDone;
                        // Load results on entry to done so they are valid with the pulse.
                        if (!wr_q) begin
                            rd_flag_d = cap_q[COUNTER_BITS];
                            rd_data_d = cap_q[COUNTER_BITS-1:0];
                        end
                    end
                end
            end
            StDone: begin
                div_d   = '0;
                state_d = StIdle;
            end
            default: begin
                state_d = StFlushLow;
            end
        endcase

        if (go) begin
            state_d    = StSetup;
            wr_d       = go_wr;
            wr_shift_d = go_wr ? wr_data_i : '0;
            bit_cnt_d  = go_wr ? BitCntW'(WrBits) : BitCntW'(RdBits);
            mosi_d     = ~go_wr;  // command bit: 1 = read, 0 = write
            cap_d      = '0;
        end
    end

    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            state_q    <= StFlushLow;
            div_q      <= '0;
            bit_cnt_q  <= '0;
            wr_q       <= 1'b0;
            wr_shift_q <= '0;
            cap_q      <= '0;
            mosi_q     <= 1'b0;
            rd_data_q  <= '0;
            rd_flag_q  <= 1'b0;
            boot_q     <= 1'b1;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            bit_cnt_q  <= bit_cnt_d;
            wr_q       <= wr_d;
            wr_shift_q <= wr_shift_d;
            cap_q      <= cap_d;
            mosi_q     <= mosi_d;
            rd_data_q  <= rd_data_d;
            rd_flag_q  <= rd_flag_d;
            boot_q     <= boot_d;
        end
    end

`ifdef GPS_AUTO_POLL_EN
    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            pps_q  <= 1'b0;
            pend_q <= 1'b0;
        end else begin
            pps_q  <= one_pps_i;
            pend_q <= pend_d;
        end
    end
`endif

    always_comb begin
        busy_o     = (state_q != StIdle);
        done_o     = (state_q == StDone);
        spi_clk_o  = (state_q == StHigh) || (state_q == StFlushHigh);
        spi_sen_o  = !((state_q == StSetup) || (state_q == StHigh) || (state_q == StLow));
        spi_mosi_o = mosi_q;
        rd_data_o  = rd_data_q;
        rd_flag_o  = rd_flag_q;
    end

endmodule

// File: tb/tb_gps_counter_spi_master.sv
// tb_gps_counter_spi_master
//   Self-checking bench for gps_counter_spi_master with a behavioural model of
//   the GPS counter SPI slave. Expected results are queued when a transaction
//   is launched and compared when done is seen.

module tb_gps_counter_spi_master;

    logic        clk;
    logic        nreset;
    logic        one_pps;
    logic        start;
    logic        wr;
    logic [27:0] wr_data;
    logic        busy;
    logic        done;
    logic [15:0] rd_data;
    logic        rd_flag;
    logic        spi_clk;
    logic        spi_sen;
    logic        spi_mosi;
    logic        spi_miso;

    gps_counter_spi_master dut (
        .clk_i      (clk),
        .nreset_i   (nreset),
`ifdef GPS_AUTO_POLL_EN
        .one_pps_i  (one_pps),
`endif
        .start_i    (start),
        .wr_i       (wr),
        .wr_data_i  (wr_data),
        .busy_o     (busy),
        .done_o     (done),
        .rd_data_o  (rd_data),
        .rd_flag_o  (rd_flag),
        .spi_clk_o  (spi_clk),
        .spi_sen_o  (spi_sen),
        .spi_mosi_o (spi_mosi),
        .spi_miso_i (spi_miso)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Slave model: edge-detects spi_clk in the clk domain.
    logic [16:0] s_tx = 17'h0;
    logic        sclk_d1 = 1'b0;
    int unsigned s_cnt = 0;
    logic [31:0] s_rx = 32'h0;
    logic [27:0] s_cmp = 28'h0;
    int unsigned last_cnt = 0;
    logic [31:0] last_rx = 32'h0;
    int unsigned flush_edges = 0;
    logic [4:0]  s_idx;

    always @(posedge clk) begin
        sclk_d1 <= spi_clk;
        if (spi_clk && !sclk_d1) begin
            if (!spi_sen) begin
                s_rx  <= {s_rx[30:0], spi_mosi};
                s_cnt <= s_cnt + 1;
            end else begin
                if (s_cnt == 29 && s_rx[28] == 1'b0) begin
                    s_cmp <= s_rx[27:0];
                end
                last_cnt    <= s_cnt;
                last_rx     <= s_rx;
                s_cnt       <= 0;
                flush_edges <= flush_edges + 1;
            end
        end
    end

    always_comb begin
        s_idx    = 5'(16 - s_cnt);
        spi_miso = 1'b0;
        if (s_cnt < 17) begin
            spi_miso = s_tx[s_idx];
        end
    end

    int unsigned done_cnt = 0;
    int unsigned sen_viol = 0;
    logic        sen_prev = 1'b1;

    always @(posedge clk) begin
        sen_prev <= spi_sen;
        if (done) begin
            done_cnt <= done_cnt + 1;
        end
        if (spi_sen != sen_prev && spi_clk) begin
            sen_viol <= sen_viol + 1;
        end
    end

    typedef struct {
        logic        wr;
        logic [27:0] cmp;
        logic [15:0] data;
        logic        flag;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] mdl_data = 16'h0;
    logic        mdl_flag = 1'b0;

    task automatic push_exp(input logic w, input logic [27:0] d);
        exp_t e;
        if (!w) begin
            mdl_flag = s_tx[16];
            mdl_data = s_tx[15:0];
        end
        e.wr   = w;
        e.cmp  = d;
        e.flag = mdl_flag;
        e.data = mdl_data;
        sb.push_back(e);
    endtask

    task automatic issue(input logic w, input logic [27:0] d);
        push_exp(w, d);
        start   = 1'b1;
        wr      = w;
        wr_data = d;
        tick();
        start   = 1'b0;
    endtask

    // Waits for done (bounded), checks latency, then pops and checks results.
    task automatic wait_done(input string tag, input int unsigned exp_lat,
                             input int unsigned lat0, input bit poke);
        int unsigned lat = lat0;
        int unsigned d0  = done_cnt;
        exp_t        e;
        if (poke) wr = 1'b1;
        while (!done && lat < 1000) begin
            start = poke && (lat == 10 || lat == 50 || lat == 100);
            tick();
            lat++;
        end
        start = 1'b0;
        check_eq({tag, "_lat"}, lat, exp_lat);
        check_eq({tag, "_busy_at_done"}, 32'(busy), 32'd1);
        tick();
        check_eq({tag, "_done_pulses"}, done_cnt - d0, 32'd1);
        check_eq({tag, "_busy_after"}, 32'(busy), 32'd0);
        if (sb.size() == 0) begin
            check_eq({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            check_eq({tag, "_rd_flag"}, 32'(rd_flag), 32'(e.flag));
            check_eq({tag, "_rd_data"}, 32'(rd_data), 32'(e.data));
            if (e.wr) begin
                check_eq({tag, "_edges"}, last_cnt, 32'd29);
                check_eq({tag, "_bits"}, {3'b0, last_rx[28:0]}, {4'b0, e.cmp});
                check_eq({tag, "_cmp"}, 32'(s_cmp), 32'(e.cmp));
            end else begin
                check_eq({tag, "_edges"}, last_cnt, 32'd17);
                check_eq({tag, "_bits"}, {15'b0, last_rx[16:0]}, 32'h1FFFF);
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int          clk_hi;
        int          rises;
        int          sen_lo;
        int          busy_hi;
        int          done_hi;
        logic        prev_clk;
        int          guard;
        int unsigned fe0;

        nreset  = 1'b0;
        one_pps = 1'b0;
        start   = 1'b0;
        wr      = 1'b0;
        wr_data = 28'h0;
        s_tx    = {1'b1, 16'hA5C3};

        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_outs", {26'b0, busy, done, spi_sen, spi_clk, spi_mosi, rd_flag},
                 32'b101000);
        check_eq("rst_rd_data", 32'(rd_data), 32'd0);

        // Reset release: one flush pulse, busy for 8 cycles, no done.
        nreset   = 1'b1;
        clk_hi   = 0;
        rises    = 0;
        sen_lo   = 0;
        busy_hi  = 0;
        done_hi  = 0;
        prev_clk = 1'b0;
        for (int i = 0; i < 14; i++) begin
            if (spi_clk) clk_hi++;
            if (spi_clk && !prev_clk) rises++;
            if (!spi_sen) sen_lo++;
            if (busy) busy_hi++;
            if (done) done_hi++;
            prev_clk = spi_clk;
            tick();
        end
        check_eq("boot_busy_cycles", busy_hi, 8);
        check_eq("boot_sclk_high", clk_hi, 4);
        check_eq("boot_sclk_rises", rises, 1);
        check_eq("boot_sen_low", sen_lo, 0);
        check_eq("boot_done", done_hi, 0);
        check_eq("boot_flush_edges", flush_edges, 32'd1);
        check_eq("boot_rd", {15'b0, rd_flag, rd_data}, 32'd0);

        // Read with ignored starts while busy, then back-to-back write.
        issue(1'b0, 28'h0);
        wait_done("rd1", 145, 1, 1'b1);
        issue(1'b1, 28'h8000001);
        wr_data = 28'hFFFFFFF;
        wait_done("wr1", 241, 1, 1'b0);

        s_tx = {1'b0, 16'h5A3C};
        issue(1'b0, 28'h0);
        wait_done("rd2", 145, 1, 1'b0);

        // Reset in the middle of a write at bit 12.
        issue(1'b1, 28'h5A5A5A5);
        guard = 0;
        while (s_cnt != 12 && guard < 600) begin
            tick();
            guard++;
        end
        check_eq("mid_wait_bit12", s_cnt, 32'd12);
        fe0    = flush_edges;
        nreset = 1'b0;
        #1;
        check_eq("mid_rst_sen_sclk", {30'b0, spi_sen, spi_clk}, 32'b10);
        check_eq("mid_rst_rd", {15'b0, rd_flag, rd_data}, 32'd0);
        tick();
        nreset = 1'b1;
        void'(sb.pop_back());
        mdl_flag = 1'b0;
        mdl_data = 16'h0;
        guard = 0;
        while (busy && guard < 50) begin
            tick();
            guard++;
        end
        check_eq("mid_back_idle", 32'(busy), 32'd0);
        check_eq("mid_flush_edge", flush_edges - fe0, 32'd1);
        check_eq("mid_slave_cnt", s_cnt, 32'd0);
        check_eq("mid_cmp_kept", 32'(s_cmp), 32'h8000001);

        s_tx = {1'b1, 16'h0001};
        issue(1'b0, 28'h0);
        wait_done("rd3", 145, 1, 1'b0);

`ifdef GPS_AUTO_POLL_EN
        // Edge while idle launches a read on the next clock.
        push_exp(1'b0, 28'h0);
        one_pps = 1'b1;
        tick();
        one_pps = 1'b0;
        check_eq("poll_launch", 32'(busy), 32'd1);
        wait_done("poll_idle", 145, 1, 1'b0);

        // Two edges during a write give exactly one read right after it.
        s_tx = {1'b0, 16'hBEEF};
        issue(1'b1, 28'h0123456);
        repeat (20) tick();
        one_pps = 1'b1;
        tick();
        one_pps = 1'b0;
        repeat (5) tick();
        one_pps = 1'b1;
        tick();
        one_pps = 1'b0;
        push_exp(1'b0, 28'h0);
        wait_done("poll_wr", 241, 28, 1'b0);
        tick();
        check_eq("poll_after_wr_launch", 32'(busy), 32'd1);
        wait_done("poll_rd", 145, 1, 1'b0);
        busy_hi = 0;
        for (int i = 0; i < 20; i++) begin
            if (busy) busy_hi++;
            tick();
        end
        check_eq("poll_single", busy_hi, 0);
`endif

        check_eq("sen_while_sclk", sen_viol, 32'd0);
        check_eq("sb_drained", sb.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
